// File: rtl/eclsensor_pkg.sv
// Shared definitions for the ECL sensor command receiver and the IR scanner:
// FSM encodings, command letters, default slot timing and a hex-digit decoder.
package eclsensor_pkg;

  localparam int kDefaultBurst = 190;
  localparam int kDefaultQuiet = 38;

  localparam logic [7:0] kCmdMask  = 8'h4D;  // 'M'
  localparam logic [7:0] kCmdBurst = 8'h42;  // 'B'
  localparam logic [7:0] kCmdQuiet = 8'h51;  // 'Q'
  localparam logic [7:0] kChCr     = 8'h0D;
  localparam logic [7:0] kChLf     = 8'h0A;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_BREAK
  } uart_state_e;

  typedef enum logic [2:0] {
    P_IDLE,
    P_H1,
    P_H2,
    P_H3,
    P_EOL
  } parse_state_e;

  typedef enum logic [1:0] {
    F_MASK,
    F_BURST,
    F_QUIET
  } field_e;

  typedef struct packed {
    logic mask;
    logic burst;
    logic quiet;
  } cfg_dirty_t;

  // Returns {valid, nybble}; valid is 0 for anything outside 0-9, a-f, A-F.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    return r;
  endfunction

endpackage

// File: rtl/eclsensor_uart_rx.sv
// 8-N-1 UART receiver: two-flop synchronizer, optional line inversion,
// mid-bit sampling, one-cycle byte_valid_o and framing_error_o pulses.
module eclsensor_uart_rx
  import eclsensor_pkg::*;
#(
  parameter int kClockHz      = 25_000_000,
  parameter int kBaudRate     = 921_600,
  parameter int kSerialInvert = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       framing_error_o
);

  localparam int kBitClocks = kClockHz / kBaudRate;
  localparam int kCntW      = $clog2(kBitClocks);
  localparam logic [kCntW-1:0] kHalfBit = kCntW'(kBitClocks / 2);
  localparam logic [kCntW-1:0] kFullBit = kCntW'(kBitClocks - 1);
  localparam logic kInv = kSerialInvert[0];

  logic [1:0]       sync_q;
  logic             rx_bit;
  uart_state_e      state_q, state_d;
  logic [kCntW-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             framing_q, framing_d;

  assign rx_bit = sync_q[1] ^ kInv;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    framing_d    = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        if (!rx_bit) begin
          state_d = R_START;
          cnt_d   = kHalfBit;
        end
      end
      R_START: begin
        if (cnt_q == '0) begin
          if (rx_bit) begin
            state_d = R_IDLE;
          end else begin
            state_d   = R_DATA;
            cnt_d     = kFullBit;
            bit_idx_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - kCntW'(1);
        end
      end
      R_DATA: begin
        if (cnt_q == '0) begin
          shift_d   = {rx_bit, shift_q[7:1]};
          cnt_d     = kFullBit;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = R_STOP;
        end else begin
          cnt_d = cnt_q - kCntW'(1);
        end
      end
      R_STOP: begin
        if (cnt_q == '0) begin
          if (rx_bit) begin
            byte_valid_d = 1'b1;
            state_d      = R_IDLE;
          end else begin
            framing_d = 1'b1;
            state_d   = R_BREAK;
          end
        end else begin
          cnt_d = cnt_q - kCntW'(1);
        end
      end
      // A held-low line must not be mistaken for a fresh start bit.
      R_BREAK: begin
        if (rx_bit) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= {2{~kInv}};
      state_q      <= R_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      byte_valid_q <= 1'b0;
      framing_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], rxd_i};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      framing_q    <= framing_d;
    end
  end

  assign byte_valid_o    = byte_valid_q;
  assign byte_data_o     = shift_q;
  assign framing_error_o = framing_q;

endmodule

// File: rtl/eclsensor_cmd_rx.sv
// ASCII config command receiver: parses M/B/Q hex commands into pending values
// that go live on the scanner's apply_ok strobe. ECLCMD_ERRCOUNT_EN adds err_count.
module eclsensor_cmd_rx #(
  parameter int          kClockHz      = 25_000_000,
  parameter int          kSerialInvert = 1,
  parameter int          kBaudRate     = 921_600,
  parameter int          kTxCount      = 12,
  parameter logic [11:0] kDefaultMask  = 12'hFFF,
  parameter int          kDefaultBurst = eclsensor_pkg::kDefaultBurst,
  parameter int          kDefaultQuiet = eclsensor_pkg::kDefaultQuiet
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxd,
  input  logic                apply_ok,
  output logic [kTxCount-1:0] tx_mask,
  output logic [11:0]         burst_cycles,
  output logic [11:0]         quiet_cycles,
  output logic                cfg_applied,
  output logic                cmd_error
`ifdef ECLCMD_ERRCOUNT_EN
  ,
  output logic [7:0]          err_count
`endif
);

  import eclsensor_pkg::*;

  localparam logic [kTxCount-1:0] kMaskInit  = kDefaultMask[kTxCount-1:0];
  localparam logic [11:0]         kBurstInit = 12'(kDefaultBurst);
  localparam logic [11:0]         kQuietInit = 12'(kDefaultQuiet);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       framing_error;

  eclsensor_uart_rx #(
    .kClockHz     (kClockHz),
    .kBaudRate    (kBaudRate),
    .kSerialInvert(kSerialInvert)
  ) u_uart (
    .clk            (clk),
    .reset          (reset),
    .rxd_i          (rxd),
    .byte_valid_o   (byte_valid),
    .byte_data_o    (byte_data),
    .framing_error_o(framing_error)
  );

  parse_state_e        p_state_q, p_state_d;
  field_e              field_q, field_d;
  logic [11:0]         acc_q, acc_d;
  logic [kTxCount-1:0] pend_mask_q, pend_mask_d, mask_q;
  logic [11:0]         pend_burst_q, pend_burst_d, burst_q;
  logic [11:0]         pend_quiet_q, pend_quiet_d, quiet_q;
  cfg_dirty_t          dirty_q, dirty_d, commit_set;
  logic                parse_err;
  logic                apply_fire;
  logic                cfg_applied_q, cmd_error_q;
  logic [4:0]          hex;

  always_comb begin
    p_state_d    = p_state_q;
    field_d      = field_q;
    acc_d        = acc_q;
    pend_mask_d  = pend_mask_q;
    pend_burst_d = pend_burst_q;
    pend_quiet_d = pend_quiet_q;
    commit_set   = '0;
    parse_err    = 1'b0;
    hex          = hex_decode(byte_data);

    if (framing_error) begin
      p_state_d = P_IDLE;
    end else if (byte_valid && byte_data != kChCr) begin
      unique case (p_state_q)
        P_IDLE: begin
          p_state_d = P_H1;
          acc_d     = '0;
          if (byte_data == kCmdMask)       field_d = F_MASK;
          else if (byte_data == kCmdBurst) field_d = F_BURST;
          else if (byte_data == kCmdQuiet) field_d = F_QUIET;
          else begin
            p_state_d = P_IDLE;
            parse_err = (byte_data != kChLf);
          end
        end
        P_H1, P_H2, P_H3: begin
          if (hex[4]) begin
            acc_d     = {acc_q[7:0], hex[3:0]};
            p_state_d = (p_state_q == P_H1) ? P_H2 :
                        (p_state_q == P_H2) ? P_H3 : P_EOL;
          end else begin
            parse_err = 1'b1;
            p_state_d = P_IDLE;
          end
        end
        P_EOL: begin
          p_state_d = P_IDLE;
          if (byte_data != kChLf) begin
            parse_err = 1'b1;
          end else begin
            // Burst and quiet may not both end up zero: the scanner would spin.
            unique case (field_q)
              F_MASK: begin
                pend_mask_d     = acc_q[kTxCount-1:0];
                commit_set.mask = 1'b1;
              end
              F_BURST: begin
                if (acc_q == '0 && pend_quiet_q == '0) begin
                  parse_err = 1'b1;
                end else begin
                  pend_burst_d     = acc_q;
                  commit_set.burst = 1'b1;
                end
              end
              F_QUIET: begin
                if (acc_q == '0 && pend_burst_q == '0) begin
                  parse_err = 1'b1;
                end else begin
                  pend_quiet_d     = acc_q;
                  commit_set.quiet = 1'b1;
                end
              end
              default: parse_err = 1'b1;
            endcase
          end
        end
        default: p_state_d = P_IDLE;
      endcase
    end
  end

  // A commit landing on the apply cycle keeps its dirty bit for the next strobe.
  assign apply_fire    = apply_ok && (dirty_q != '0);
  assign dirty_d.mask  = commit_set.mask  | (dirty_q.mask  & ~apply_fire);
  assign dirty_d.burst = commit_set.burst | (dirty_q.burst & ~apply_fire);
  assign dirty_d.quiet = commit_set.quiet | (dirty_q.quiet & ~apply_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      p_state_q     <= P_IDLE;
      field_q       <= F_MASK;
      acc_q         <= '0;
      pend_mask_q   <= kMaskInit;
      pend_burst_q  <= kBurstInit;
      pend_quiet_q  <= kQuietInit;
      mask_q        <= kMaskInit;
      burst_q       <= kBurstInit;
      quiet_q       <= kQuietInit;
      dirty_q       <= '0;
      cfg_applied_q <= 1'b0;
      cmd_error_q   <= 1'b0;
    end else begin
      p_state_q     <= p_state_d;
      field_q       <= field_d;
      acc_q         <= acc_d;
      pend_mask_q   <= pend_mask_d;
      pend_burst_q  <= pend_burst_d;
      pend_quiet_q  <= pend_quiet_d;
      dirty_q       <= dirty_d;
      cfg_applied_q <= apply_fire;
      cmd_error_q   <= parse_err | framing_error;
      if (apply_fire) begin
        if (dirty_q.mask)  mask_q  <= pend_mask_q;
        if (dirty_q.burst) burst_q <= pend_burst_q;
        if (dirty_q.quiet) quiet_q <= pend_quiet_q;
      end
    end
  end

  assign tx_mask      = mask_q;
  assign burst_cycles = burst_q;
  assign quiet_cycles = quiet_q;
  assign cfg_applied  = cfg_applied_q;
  assign cmd_error    = cmd_error_q;

`ifdef ECLCMD_ERRCOUNT_EN
  logic [7:0] err_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= 8'd0;
    end else if (cmd_error_q && err_count_q != 8'hFF) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_eclsensor_cmd_rx.sv
// Scoreboard bench for eclsensor_cmd_rx: a character-level command model
// queues expected apply/error events, a monitor consumes them as the DUT pulses.
module tb_eclsensor_cmd_rx;

  localparam int   kBit = 27;
  localparam logic kInv = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rxd = 1'b0;
  logic        apply_ok = 1'b0;
  logic [11:0] tx_mask, burst_cycles, quiet_cycles;
  logic        cfg_applied, cmd_error;
`ifdef ECLCMD_ERRCOUNT_EN
  logic [7:0]  err_count;
`endif

  always #20 clk = ~clk;

  eclsensor_cmd_rx dut (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .apply_ok    (apply_ok),
    .tx_mask     (tx_mask),
    .burst_cycles(burst_cycles),
    .quiet_cycles(quiet_cycles),
    .cfg_applied (cfg_applied),
    .cmd_error   (cmd_error)
`ifdef ECLCMD_ERRCOUNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [11:0] mask;
    logic [11:0] burst;
    logic [11:0] quiet;
  } cfg_t;

  cfg_t        apply_q[$];
  string       err_q[$];
  logic [11:0] m_pend_mask, m_pend_burst, m_pend_quiet;
  logic [11:0] m_live_mask, m_live_burst, m_live_quiet;
  bit          m_dm, m_db, m_dq;
  int          m_pos;
  logic [7:0]  m_field;
  int          m_acc;
  int          m_err_total = 0;

  function automatic int hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    return -1;
  endfunction

  task automatic push_err(input string why);
    err_q.push_back(why);
    m_err_total++;
  endtask

  task automatic model_reset();
    m_pend_mask = 12'hFFF; m_pend_burst = 12'd190; m_pend_quiet = 12'd38;
    m_live_mask = 12'hFFF; m_live_burst = 12'd190; m_live_quiet = 12'd38;
    m_dm = 0; m_db = 0; m_dq = 0;
    m_pos = 0; m_acc = 0; m_field = 8'h00;
    apply_q.delete();
    err_q.delete();
    m_err_total = 0;
  endtask

  task automatic model_commit();
    if (m_field == 8'h4D) begin
      m_pend_mask = 12'(m_acc % 4096);
      m_dm = 1;
    end else if (m_field == 8'h42) begin
      if (m_acc + int'(m_pend_quiet) == 0) push_err("burst+quiet zero");
      else begin m_pend_burst = 12'(m_acc); m_db = 1; end
    end else begin
      if (m_acc + int'(m_pend_burst) == 0) push_err("burst+quiet zero");
      else begin m_pend_quiet = 12'(m_acc); m_dq = 1; end
    end
  endtask

  // m_pos: 0 = waiting for a letter, 1..3 = digits taken + 1, 4 = waiting for newline
  task automatic model_byte(input logic [7:0] c);
    if (c == 8'h0D) return;
    if (m_pos == 0) begin
      if (c == 8'h4D || c == 8'h42 || c == 8'h51) begin
        m_field = c; m_acc = 0; m_pos = 1;
      end else if (c != 8'h0A) begin
        push_err("stray byte");
      end
    end else if (m_pos <= 3) begin
      if (hex_val(c) >= 0) begin
        m_acc = (m_acc * 16 + hex_val(c)) % 4096;
        m_pos++;
      end else begin
        push_err("bad digit");
        m_pos = 0;
      end
    end else begin
      m_pos = 0;
      if (c != 8'h0A) push_err("no newline");
      else model_commit();
    end
  endtask

  task automatic model_apply();
    if (m_dm || m_db || m_dq) begin
      if (m_dm) m_live_mask = m_pend_mask;
      if (m_db) m_live_burst = m_pend_burst;
      if (m_dq) m_live_quiet = m_pend_quiet;
      apply_q.push_back('{m_live_mask, m_live_burst, m_live_quiet});
      m_dm = 0; m_db = 0; m_dq = 0;
    end
  endtask

  // ---------------- monitor ----------------
  logic [11:0] last_mask, last_burst, last_quiet;
  logic        last_edge_apply = 1'b0;
  int          cfg_pulses = 0;
  int          err_pulses = 0;
  cfg_t        mon_e;

  always @(posedge clk) last_edge_apply = apply_ok;

  always @(negedge clk) begin
    if (!reset) begin
      if (cfg_applied) begin
        cfg_pulses++;
        check("cfg_applied has queued expectation", 64'(apply_q.size() != 0), 64'd1);
        if (apply_q.size() != 0) begin
          mon_e = apply_q.pop_front();
          check("applied tx_mask", 64'(tx_mask), 64'(mon_e.mask));
          check("applied burst_cycles", 64'(burst_cycles), 64'(mon_e.burst));
          check("applied quiet_cycles", 64'(quiet_cycles), 64'(mon_e.quiet));
          check("cfg_applied one cycle after apply_ok", 64'(last_edge_apply), 64'd1);
        end
      end else if ({tx_mask, burst_cycles, quiet_cycles} != {last_mask, last_burst, last_quiet}) begin
        check("live outputs stable without cfg_applied",
              64'({tx_mask, burst_cycles, quiet_cycles}),
              64'({last_mask, last_burst, last_quiet}));
      end
      if (cmd_error) begin
        err_pulses++;
        check("cmd_error has queued expectation", 64'(err_q.size() != 0), 64'd1);
        if (err_q.size() != 0) void'(err_q.pop_front());
      end
    end
    last_mask  = tx_mask;
    last_burst = burst_cycles;
    last_quiet = quiet_cycles;
  end

  // ---------------- driver ----------------
  logic [7:0] tx_buf[$];

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    logic [9:0] frame;
    frame = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = frame[i] ^ kInv;
      wait_cycles(kBit);
    end
    if (!stop_ok) begin
      rxd = 1'b1 ^ kInv;
      wait_cycles(kBit);
    end
  endtask

  task automatic send_buf();
    foreach (tx_buf[i]) begin
      model_byte(tx_buf[i]);
      send_byte(tx_buf[i], 1'b1);
    end
    tx_buf.delete();
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) tx_buf.push_back(s[i]);
  endtask

  task automatic send_cmd(input string s, input bit with_cr);
    push_str(s);
    if (with_cr) tx_buf.push_back(8'h0D);
    tx_buf.push_back(8'h0A);
    send_buf();
  endtask

  task automatic do_apply();
    apply_ok = 1'b1;
    model_apply();
    wait_cycles(1);
    apply_ok = 1'b0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int    c0, e0, sel;
    bit    zero;
    string hexchars;
    hexchars = "0123456789abcdefABCDEF";

    model_reset();
    reset = 1'b1;
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(2);

    check("reset tx_mask", 64'(tx_mask), 64'hFFF);
    check("reset burst_cycles", 64'(burst_cycles), 64'd190);
    check("reset quiet_cycles", 64'(quiet_cycles), 64'd38);
    check("reset cfg_applied", 64'(cfg_applied), 64'd0);
    check("reset cmd_error", 64'(cmd_error), 64'd0);

    // Idle line with apply_ok held: nothing is dirty, nothing may happen.
    c0 = cfg_pulses; e0 = err_pulses;
    apply_ok = 1'b1;
    wait_cycles(10000);
    apply_ok = 1'b0;
    wait_cycles(3);
    check("idle cfg_applied pulses", 64'(cfg_pulses - c0), 64'd0);
    check("idle cmd_error pulses", 64'(err_pulses - e0), 64'd0);
    check("idle tx_mask", 64'(tx_mask), 64'hFFF);
    check("idle burst_cycles", 64'(burst_cycles), 64'd190);

    // Burst command, delayed apply, then a redundant apply.
    send_cmd("B0FA", 0);
    wait_cycles(100);
    c0 = cfg_pulses;
    check("burst not live before apply", 64'(burst_cycles), 64'd190);
    do_apply();
    check("burst live one cycle after strobe", 64'(burst_cycles), 64'd250);
    wait_cycles(3);
    do_apply();
    wait_cycles(3);
    check("single pulse for burst apply", 64'(cfg_pulses - c0), 64'd1);

    // Two fields applied together.
    c0 = cfg_pulses;
    send_cmd("M00f", 1);
    send_cmd("Q010", 0);
    wait_cycles(20);
    do_apply();
    wait_cycles(3);
    check("mask after joint apply", 64'(tx_mask), 64'h00F);
    check("quiet after joint apply", 64'(quiet_cycles), 64'd16);
    check("single pulse for joint apply", 64'(cfg_pulses - c0), 64'd1);

    // Bad digit: error on 'x', then '1' and '2' are stray at idle.
    e0 = err_pulses;
    send_cmd("Bx12", 0);
    wait_cycles(10);
    check("errors from Bx12", 64'(err_pulses - e0), 64'd3);
    send_cmd("B012", 0);
    wait_cycles(10);
    do_apply();
    wait_cycles(3);
    check("burst after recovery", 64'(burst_cycles), 64'd18);

    // Zero quiet is legal while burst is nonzero; zero burst then is not.
    e0 = err_pulses;
    send_cmd("Q000", 0);
    send_cmd("B000", 0);
    wait_cycles(10);
    check("error from zero burst+quiet", 64'(err_pulses - e0), 64'd1);
    do_apply();
    wait_cycles(3);
    check("quiet zero applied", 64'(quiet_cycles), 64'd0);
    check("burst kept after rejection", 64'(burst_cycles), 64'd18);

    // Framing error in the middle of a Q command.
    e0 = err_pulses;
    push_str("Q0");
    send_buf();
    push_err("framing");
    m_pos = 0;
    send_byte(8'h55, 1'b0);
    wait_cycles(10);
    check("framing error pulse", 64'(err_pulses - e0), 64'd1);
    check("quiet unchanged after framing", 64'(quiet_cycles), 64'd0);
    send_cmd("Q020", 0);
    wait_cycles(10);
    do_apply();
    wait_cycles(3);
    check("quiet after framing recovery", 64'(quiet_cycles), 64'd32);
    check("no extra errors after framing", 64'(err_pulses - e0), 64'd1);

    // Reset while a mask command sits in P_H2 with a byte in flight.
    push_str("M0");
    send_buf();
    rxd = 1'b0 ^ kInv;
    wait_cycles(kBit);
    rxd = 1'b1 ^ kInv;
    wait_cycles(10);
    check("no pending applies before reset", 64'(apply_q.size()), 64'd0);
    check("no pending errors before reset", 64'(err_q.size()), 64'd0);
    reset = 1'b1;
    model_reset();
    wait_cycles(4);
    rxd = 1'b1 ^ kInv;
    reset = 1'b0;
    wait_cycles(300);
    check("mask default after mid reset", 64'(tx_mask), 64'hFFF);
    check("quiet default after mid reset", 64'(quiet_cycles), 64'd38);
    send_cmd("M001", 0);
    wait_cycles(10);
    do_apply();
    wait_cycles(3);
    check("mask after post-reset command", 64'(tx_mask), 64'h001);
    check("burst default after post-reset command", 64'(burst_cycles), 64'd190);

    // Randomized commands, corrupted digits, stray CRs and random applies.
    for (int n = 0; n < 20; n++) begin
      sel = $urandom_range(0, 9);
      tx_buf.push_back(sel == 0 ? 8'h5A : sel < 4 ? 8'h4D : sel < 7 ? 8'h42 : 8'h51);
      zero = ($urandom_range(0, 4) == 0);
      for (int d = 0; d < 3; d++)
        tx_buf.push_back(zero ? 8'h30 : hexchars[$urandom_range(0, 21)]);
      if ($urandom_range(0, 7) == 0) tx_buf[$urandom_range(1, 3)] = 8'h67;
      if ($urandom_range(0, 3) == 0) tx_buf.insert($urandom_range(0, 4), 8'h0D);
      tx_buf.push_back(8'h0A);
      send_buf();
      wait_cycles($urandom_range(2, 40));
      if ($urandom_range(0, 2) != 0) do_apply();
    end

    wait_cycles(20);
    do_apply();
    wait_cycles(20);
    check("all expected applies seen", 64'(apply_q.size()), 64'd0);
    check("all expected errors seen", 64'(err_q.size()), 64'd0);
    check("final tx_mask", 64'(tx_mask), 64'(m_live_mask));
    check("final burst_cycles", 64'(burst_cycles), 64'(m_live_burst));
    check("final quiet_cycles", 64'(quiet_cycles), 64'(m_live_quiet));
`ifdef ECLCMD_ERRCOUNT_EN
    check("err_count", 64'(err_count), 64'(m_err_total > 255 ? 255 : m_err_total));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
